mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_pkg.sv | 84 ++++++++
 rtl/mc_control_unit_instr_class_decoder.sv | 41 ++++
 rtl/mc_control_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, function codes,
// FSM state encoding, mux-select values and the class/control payload structs.
package mc_control_unit_pkg;

    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned FUNC_CODE_W = 6;
    localparam int unsigned ALU_SEL_BIT = 3;

    localparam logic [OPCODE_W-1:0] OP_BNE = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_BGZ = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_BLZ = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_ADI = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_ORI = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_LHI = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_LWD = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_SWD = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_JAL = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_ALU = 4'd15;

    // Special R-type function codes; plain ALU ops are any func with bit 3 clear.
    localparam logic [FUNC_CODE_W-1:0] FN_JPR = 6'd25;
    localparam logic [FUNC_CODE_W-1:0] FN_JRL = 6'd26;
    localparam logic [FUNC_CODE_W-1:0] FN_WWD = 6'd28;
    localparam logic [FUNC_CODE_W-1:0] FN_HLT = 6'd29;

    localparam logic [1:0] PCSRC_INC    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_TARGET = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] WREG_RT   = 2'd0;
    localparam logic [1:0] WREG_RD   = 2'd1;
    localparam logic [1:0] WREG_LINK = 2'd2;

    localparam logic [1:0] ALUB_REG = 2'd0;
    localparam logic [1:0] ALUB_IMM = 2'd1;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // Exactly one flag is set for any instruction word.
    typedef struct packed {
        logic is_alu;
        logic is_imm;
        logic is_lwd;
        logic is_swd;
        logic is_branch;
        logic is_jmp;
        logic is_jal;
        logic is_jpr;
        logic is_jrl;
        logic is_wwd;
        logic is_hlt;
        logic is_undef;
    } instr_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] write_reg;
        logic       wwd_en;
        logic       inst_done;
        logic       is_halted;
    } ctl_t;

endpackage

// File: rtl/mc_control_unit_instr_class_decoder.sv
// Combinational opcode/func classifier producing one-hot instruction class flags.
module instr_class_decoder
    import mc_control_unit_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned FUNC_W  = 6
) (
    input  logic [INSTR_W-1:0] instr,
    output instr_class_t       cls_c
);

    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   func;
    logic                unused_instr_bits;

    assign opcode            = instr[INSTR_W-1 -: OPCODE_W];
    assign func              = instr[FUNC_W-1:0];
    assign unused_instr_bits = ^instr;

    always_comb begin
        cls_c = '0;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls_c.is_branch = 1'b1;
            OP_ADI, OP_ORI, OP_LHI:         cls_c.is_imm    = 1'b1;
            OP_LWD:                         cls_c.is_lwd    = 1'b1;
            OP_SWD:                         cls_c.is_swd    = 1'b1;
            OP_JMP:                         cls_c.is_jmp    = 1'b1;
            OP_JAL:                         cls_c.is_jal    = 1'b1;
            OP_ALU: begin
                if (!func[ALU_SEL_BIT])               cls_c.is_alu   = 1'b1;
                else if (func == FUNC_W'(FN_JPR))     cls_c.is_jpr   = 1'b1;
                else if (func == FUNC_W'(FN_JRL))     cls_c.is_jrl   = 1'b1;
                else if (func == FUNC_W'(FN_WWD))     cls_c.is_wwd   = 1'b1;
                else if (func == FUNC_W'(FN_HLT))     cls_c.is_hlt   = 1'b1;
                else                                  cls_c.is_undef = 1'b1;
            end
            default:                        cls_c.is_undef  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control FSM (IF/ID/EX/MEM/WB/HALT) with retired-instruction counter.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned FUNC_W  = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               pc_to_reg,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [1:0]         write_reg,
    output logic               wwd_en,
    output logic               inst_done,
    output logic               is_halted,
    output logic [CNT_W-1:0]   num_inst
);

    state_t       state;
    state_t       state_next;
    instr_class_t cls_c;
    ctl_t         ctl_c;
    ctl_t         ctl;

    instr_class_decoder #(
        .INSTR_W (INSTR_W),
        .FUNC_W  (FUNC_W)
    ) u_instr_class_decoder (
        .instr (instr),
        .cls_c (cls_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IF;
        else          state <= state_next;
    end

    // Next state and per-state controls; anything not driven below stays 0.
    always_comb begin
        state_next = state;
        ctl_c      = '0;
        case (state)
            S_IF: begin
                ctl_c.mem_read = 1'b1;
                if (mem_ready) begin
                    ctl_c.ir_write  = 1'b1;
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = PCSRC_INC;
                    state_next      = S_ID;
                end
            end
            S_ID: begin
                if (cls_c.is_jmp || cls_c.is_jal) begin
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = PCSRC_TARGET;
                    ctl_c.inst_done = 1'b1;
                    if (cls_c.is_jal) begin
                        ctl_c.reg_write = 1'b1;
                        ctl_c.pc_to_reg = 1'b1;
                        ctl_c.write_reg = WREG_LINK;
                    end
                    state_next = S_IF;
                end else if (cls_c.is_hlt) begin
                    ctl_c.inst_done = 1'b1;
                    state_next      = S_HALT;
                end else if (cls_c.is_undef) begin
                    ctl_c.inst_done = 1'b1;
                    state_next      = S_IF;
                end else begin
                    state_next = S_EX;
                end
            end
            S_EX: begin
                state_next = S_IF;
                if (cls_c.is_branch) begin
                    ctl_c.pc_write_cond = 1'b1;
                    ctl_c.pc_source     = PCSRC_BRANCH;
                    ctl_c.alu_src_b     = ALUB_REG;
                    ctl_c.inst_done     = 1'b1;
                end else if (cls_c.is_jpr || cls_c.is_jrl) begin
                    ctl_c.pc_write  = 1'b1;
                    ctl_c.pc_source = PCSRC_REG;
                    ctl_c.inst_done = 1'b1;
                    if (cls_c.is_jrl) begin
                        ctl_c.reg_write = 1'b1;
                        ctl_c.pc_to_reg = 1'b1;
                        ctl_c.write_reg = WREG_LINK;
                    end
                end else if (cls_c.is_wwd) begin
                    ctl_c.wwd_en    = 1'b1;
                    ctl_c.inst_done = 1'b1;
                end else if (cls_c.is_lwd || cls_c.is_swd) begin
                    ctl_c.alu_src_b = ALUB_IMM;
                    state_next      = S_MEM;
                end else if (cls_c.is_imm) begin
                    ctl_c.alu_src_b = ALUB_IMM;
                    state_next      = S_WB;
                end else if (cls_c.is_alu) begin
                    ctl_c.alu_src_b = ALUB_REG;
                    state_next      = S_WB;
                end
            end
            S_MEM: begin
                ctl_c.i_or_d    = 1'b1;
                ctl_c.mem_read  = cls_c.is_lwd;
                ctl_c.mem_write = cls_c.is_swd;
                if (mem_ready) begin
                    if (cls_c.is_lwd) begin
                        state_next = S_WB;
                    end else begin
                        ctl_c.inst_done = cls_c.is_swd;
                        state_next      = S_IF;
                    end
                end
            end
            S_WB: begin
                ctl_c.reg_write  = 1'b1;
                ctl_c.inst_done  = 1'b1;
                ctl_c.mem_to_reg = cls_c.is_lwd;
                ctl_c.write_reg  = cls_c.is_alu ? WREG_RD : WREG_RT;
                state_next       = S_IF;
            end
            S_HALT: begin
                ctl_c.is_halted = 1'b1;
            end
            default: begin
                state_next = S_IF;
            end
        endcase
    end

    // Reset must silence every control immediately, not just at the next edge.
    assign ctl = reset_n ? ctl_c : '0;

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign i_or_d        = ctl.i_or_d;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign pc_to_reg     = ctl.pc_to_reg;
    assign alu_src_b     = ctl.alu_src_b;
    assign pc_source     = ctl.pc_source;
    assign write_reg     = ctl.write_reg;
    assign wwd_en        = ctl.wwd_en;
    assign inst_done     = ctl.inst_done;
    assign is_halted     = ctl.is_halted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       num_inst <= '0;
        else if (inst_done) num_inst <= num_inst + CNT_W'(1);
    end

endmodule
